aes_decryption_iter: RTL

//  Iterative AES-256 inverse cipher (FIPS-197 §5.3): one round per clock, 14 rounds per block.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_dec_round.sv | 46 ++++
 rtl/aes_decryption_iter.sv | 102 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared AES constants, FSM state type and GF(2^8) helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int BLOCK_W     = 128;
    localparam int NUM_ROUNDS  = 14;
    localparam int KEY_CHAIN_W = (NUM_ROUNDS + 1) * BLOCK_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_dec_round.sv
// ============================================================================
// aes_dec_round : one combinational AES inverse-cipher round
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module aes_dec_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] key_i,
    input  logic               final_i,
    output logic [BLOCK_W-1:0] state_o
);

    logic [7:0] w_ark [16];
    logic [7:0] w_mix [16];

    // Byte n sits at row n%4, column n/4; InvShiftRows pulls row r from column c-r.
    generate
        for (genvar n = 0; n < 16; n++) begin : g_byte
            localparam int ROW = n % 4;
            localparam int COL = n / 4;
            localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
            assign w_ark[n] = inv_sbox(state_i[BLOCK_W-1-8*SRC -: 8]) ^ key_i[BLOCK_W-1-8*n -: 8];
        end

        for (genvar c = 0; c < 4; c++) begin : g_col
            assign w_mix[4*c+0] = gf_mul(w_ark[4*c+0], 8'h0e) ^ gf_mul(w_ark[4*c+1], 8'h0b)
                                ^ gf_mul(w_ark[4*c+2], 8'h0d) ^ gf_mul(w_ark[4*c+3], 8'h09);
            assign w_mix[4*c+1] = gf_mul(w_ark[4*c+0], 8'h09) ^ gf_mul(w_ark[4*c+1], 8'h0e)
                                ^ gf_mul(w_ark[4*c+2], 8'h0b) ^ gf_mul(w_ark[4*c+3], 8'h0d);
            assign w_mix[4*c+2] = gf_mul(w_ark[4*c+0], 8'h0d) ^ gf_mul(w_ark[4*c+1], 8'h09)
                                ^ gf_mul(w_ark[4*c+2], 8'h0e) ^ gf_mul(w_ark[4*c+3], 8'h0b);
            assign w_mix[4*c+3] = gf_mul(w_ark[4*c+0], 8'h0b) ^ gf_mul(w_ark[4*c+1], 8'h0d)
                                ^ gf_mul(w_ark[4*c+2], 8'h09) ^ gf_mul(w_ark[4*c+3], 8'h0e);
        end

        for (genvar n = 0; n < 16; n++) begin : g_out
            assign state_o[BLOCK_W-1-8*n -: 8] = final_i ? w_ark[n] : w_mix[n];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/aes_decryption_iter.sv
// ============================================================================
// aes_decryption_iter : iterative AES-256 inverse cipher, one round per clock
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module aes_decryption_iter
    import aes_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [BLOCK_W-1:0]     ciphertext_i,
    input  logic [KEY_CHAIN_W-1:0] key_chain_i,
    output logic                   v_o,
    input  logic                   yumi_i,
    output logic [BLOCK_W-1:0]     plaintext_o
);

    aes_state_e             r_state;
    aes_state_e             w_state_nxt;
    logic [KEY_CHAIN_W-1:0] r_key_chain;
    logic [BLOCK_W-1:0]     r_data;
    logic [3:0]             r_round_cnt;
    logic [BLOCK_W-1:0]     w_rk [16];
    logic [BLOCK_W-1:0]     w_round_key;
    logic [BLOCK_W-1:0]     w_round_out;
    logic                   w_final;
    logic                   w_accept;

    // Entry 15 is never selected; padding keeps the 4-bit mux index in range.
    generate
        for (genvar k = 0; k < 16; k++) begin : g_rk
            if (k <= NUM_ROUNDS) begin : g_used
                assign w_rk[k] = r_key_chain[KEY_CHAIN_W-1-k*BLOCK_W -: BLOCK_W];
            end else begin : g_pad
                assign w_rk[k] = '0;
            end
        end
    endgenerate

    assign w_round_key = w_rk[r_round_cnt];
    assign w_final     = (r_round_cnt == 4'd0);
    assign plaintext_o = r_data;

    aes_dec_round u_round (
        .state_i (r_data),
        .key_i   (w_round_key),
        .final_i (w_final),
        .state_o (w_round_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        v_o         = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o  = 1'b1;
                w_accept = v_i;
                if (v_i) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_final) w_state_nxt = DONE;
            end
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Initial AddRoundKey uses rk14 straight from the input so BUSY starts at round 13.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_key_chain <= '0;
            r_data      <= '0;
            r_round_cnt <= 4'd0;
        end else if (w_accept) begin
            r_key_chain <= key_chain_i;
            r_data      <= ciphertext_i ^ key_chain_i[BLOCK_W-1:0];
            r_round_cnt <= 4'd13;
        end else if (r_state == BUSY) begin
            r_data <= w_round_out;
            if (!w_final) r_round_cnt <= r_round_cnt - 4'd1;
        end
    end

endmodule

`default_nettype wire
